// File: rtl/rom_burst_reader_if.sv
// Request/response bus for rom_burst_reader: one request starts a burst of
// ROM beats that are returned under valid/ready flow control.
interface rom_burst_reader_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 6,
    parameter int unsigned MAX_BURST  = 8
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned LEN_WIDTH  = $clog2(MAX_BURST + 1);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  req_wrap;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, req_len, req_wrap, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_len, req_wrap, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Parametrised ROM with burst reads: an accepted request issues one beat per
// cycle into a one-cycle read stage feeding a 2-entry response FIFO whose head
// register drives the response outputs.
module rom_burst_reader #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           DEPTH      = 6,
    parameter logic [DATA_WIDTH-1:0] CONTENTS [DEPTH] =
        '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'hAAAA},
    parameter int unsigned           MAX_BURST  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_burst_reader_if.slave bus,
    output logic              busy
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned LEN_WIDTH  = $clog2(MAX_BURST + 1);

    localparam logic [ADDR_WIDTH:0]  DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]  LAST_A  = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_BURST);

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  err;
    } beat_t;

    state_t               state;
    logic                 req_ready_q;
    logic [ADDR_WIDTH:0]  addr_q;
    logic [LEN_WIDTH-1:0] left_q;
    logic                 wrap_q;

    logic                 if_valid;
    beat_t                if_beat;
    beat_t                head, tail;
    logic [1:0]           fifo_cnt;

    logic                 accept, pop, push, do_issue, credit_ok;
    logic                 beat_err, beat_last;
    logic [2:0]           occupancy;
    logic [ADDR_WIDTH:0]  req_addr_ext, start_addr, next_addr;
    logic [LEN_WIDTH-1:0] len_norm;
    logic [DATA_WIDTH-1:0] rom_word;

    // Request normalisation, beat address sequencing, credit and ROM lookup.
    always_comb begin
        accept       = (state == IDLE) && req_ready_q && bus.req_valid;
        pop          = (fifo_cnt != 2'd0) && bus.rsp_ready;
        push         = if_valid;
        // Pop is counted so a full pipeline keeps streaming at one beat per cycle.
        occupancy    = 3'(fifo_cnt) + 3'(if_valid) - 3'(pop);
        credit_ok    = occupancy < 3'd2;
        do_issue     = (state == ISSUE) && credit_ok;
        beat_last    = left_q == LEN_WIDTH'(1);
        beat_err     = !wrap_q && (addr_q >= DEPTH_A);

        req_addr_ext = {1'b0, bus.req_addr};
        start_addr   = req_addr_ext;
        if (bus.req_wrap && req_addr_ext >= DEPTH_A)
            start_addr = req_addr_ext - DEPTH_A;

        if (bus.req_len == '0)
            len_norm = LEN_WIDTH'(1);
        else if (bus.req_len > MAX_L)
            len_norm = MAX_L;
        else
            len_norm = bus.req_len;

        // Wrapped bursts stay below DEPTH; unwrapped ones saturate once out of range.
        if (wrap_q)
            next_addr = (addr_q == LAST_A) ? '0 : addr_q + (ADDR_WIDTH + 1)'(1);
        else
            next_addr = (addr_q >= DEPTH_A) ? addr_q : addr_q + (ADDR_WIDTH + 1)'(1);

        rom_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (addr_q == (ADDR_WIDTH + 1)'(i))
                rom_word = CONTENTS[i];
    end

    // Request FSM: accept in IDLE, issue beats under credit in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            left_q      <= '0;
            wrap_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= ISSUE;
                        req_ready_q <= 1'b0;
                        addr_q      <= start_addr;
                        left_q      <= len_norm;
                        wrap_q      <= bus.req_wrap;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (credit_ok) begin
                        addr_q <= next_addr;
                        left_q <= left_q - LEN_WIDTH'(1);
                        if (beat_last) begin
                            state       <= IDLE;
                            req_ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Synchronous ROM read into the in-flight register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_beat  <= '0;
        end else begin
            if_valid <= do_issue;
            if (do_issue)
                if_beat <= '{data: beat_err ? '0 : rom_word, last: beat_last, err: beat_err};
        end
    end

    // Two-entry response FIFO; head register drives the outputs, cleared when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            fifo_cnt <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) head <= if_beat;
                    else                  tail <= if_beat;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    head     <= (fifo_cnt == 2'd2) ? tail : '0;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd2) begin
                        head <= tail;
                        tail <= if_beat;
                    end else begin
                        head <= if_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = fifo_cnt != 2'd0;
    assign bus.rsp_data  = head.data;
    assign bus.rsp_last  = head.last;
    assign bus.rsp_err   = head.err;
    assign busy          = (state != IDLE) || if_valid || (fifo_cnt != 2'd0);

    // The credit rule guarantees the FIFO can always absorb the in-flight beat.
    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_cnt <= 2'd2);
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(if_valid && fifo_cnt == 2'd2 && !pop));
endmodule
